// File: rtl/mac_seq.sv
// rtl/mac_seq.sv - single-lane mac job sequencer; optional MAC_SEQ_SAT_FLAG_EN adds o_out_sat
`ifndef ACC_W
`define ACC_W 24
`endif
`ifndef DAT_W
`define DAT_W 32
`endif
`ifndef SF_W
`define SF_W 8
`endif
`ifndef INT4
`define INT4 2'd0
`endif
`ifndef INT8
`define INT8 2'd1
`endif
`ifndef INT4_VSQ
`define INT4_VSQ 2'd2
`endif

module mac_seq #(
  parameter int CNT_W = 8,
  parameter int ACC_W = `ACC_W,
  parameter int DAT_W = `DAT_W,
  parameter int SF_W  = `SF_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_err,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [DAT_W-1:0] i_a_data,
  input  logic [DAT_W-1:0] i_b_data,
  input  logic [SF_W-1:0]  i_a_sf,
  input  logic [SF_W-1:0]  i_b_sf,
  output logic [1:0]       o_mac_mode,
  output logic [ACC_W-1:0] o_mac_psum,
  output logic [DAT_W-1:0] o_mac_a_data,
  output logic [DAT_W-1:0] o_mac_b_data,
  output logic [SF_W-1:0]  o_mac_a_sf,
  output logic [SF_W-1:0]  o_mac_b_sf,
  input  logic [ACC_W-1:0] i_mac_result,
  output logic             o_out_valid,
  input  logic             i_out_ready,
`ifdef MAC_SEQ_SAT_FLAG_EN
  output logic             o_out_sat,
`endif
  output logic [ACC_W-1:0] o_out_data,
  output logic [1:0]       o_out_mode
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_OUT = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  len_q;
  logic [1:0]        mode_q;
  logic              err_q;

  logic in_acc, in_out, hs, mode_ok, start_ok, last_beat;

  assign in_acc    = (state == S_ACC);
  assign in_out    = (state == S_OUT);
  assign hs        = in_acc & i_in_valid;
  assign mode_ok   = (i_mode == `INT4) | (i_mode == `INT8) | (i_mode == `INT4_VSQ);
  assign start_ok  = (state == S_IDLE) & i_start & mode_ok;
  assign last_beat = (cnt == len_q - CNT_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_ok) state_nxt = (i_len == '0) ? S_OUT : S_ACC;
      S_ACC:  if (hs && last_beat) state_nxt = S_OUT;
      S_OUT:  if (i_out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= S_IDLE;
      acc    <= '0;
      cnt    <= '0;
      len_q  <= '0;
      mode_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= (state == S_IDLE) & i_start & ~mode_ok;
      if (start_ok) begin
        mode_q <= i_mode;
        len_q  <= i_len;
        acc    <= '0;
        cnt    <= '0;
      end else if (hs) begin
        acc <= i_mac_result;
        cnt <= cnt + CNT_W'(1);
      end else if (in_out && i_out_ready) begin
        acc <= '0;
      end
    end
  end

`ifdef MAC_SEQ_SAT_FLAG_EN
  // Matches either symmetric saturation limit the mac can clamp to
  localparam logic [ACC_W-1:0] SAT_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_NEG = ~SAT_POS + ACC_W'(1);
  logic sat_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      sat_q <= 1'b0;
    else if (start_ok)
      sat_q <= 1'b0;
    else if (hs && (i_mac_result == SAT_POS || i_mac_result == SAT_NEG))
      sat_q <= 1'b1;
  end

  assign o_out_sat = in_out & sat_q;
`endif

  assign o_busy       = (state != S_IDLE);
  assign o_err        = err_q;
  assign o_in_ready   = in_acc;
  assign o_mac_mode   = mode_q;
  assign o_mac_psum   = acc;
  // B side is gated on valid so the multiplier array sees no toggling on idle beats
  assign o_mac_a_data = in_acc ? i_a_data : '0;
  assign o_mac_a_sf   = in_acc ? i_a_sf : '0;
  assign o_mac_b_data = hs ? i_b_data : '0;
  assign o_mac_b_sf   = hs ? i_b_sf : '0;
  assign o_out_valid  = in_out;
  assign o_out_data   = in_out ? acc : '0;
  assign o_out_mode   = in_out ? mode_q : 2'd0;

endmodule

// File: tb/tb_mac_seq.sv
// tb/tb_mac_seq.sv - directed bench for mac_seq with a psum+1 mac model
`ifndef ACC_W
`define ACC_W 24
`endif
`ifndef DAT_W
`define DAT_W 32
`endif
`ifndef SF_W
`define SF_W 8
`endif
`ifndef INT4
`define INT4 2'd0
`endif
`ifndef INT8
`define INT8 2'd1
`endif
`ifndef INT4_VSQ
`define INT4_VSQ 2'd2
`endif

module tb_mac_seq;
  localparam int CNT_W = 8;
  localparam int ACC_W = `ACC_W;
  localparam int DAT_W = `DAT_W;
  localparam int SF_W  = `SF_W;
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};

  logic             i_clk, i_rst_n, i_start, i_in_valid, i_out_ready;
  logic [1:0]       i_mode;
  logic [CNT_W-1:0] i_len;
  logic [DAT_W-1:0] i_a_data, i_b_data;
  logic [SF_W-1:0]  i_a_sf, i_b_sf;
  logic             o_busy, o_err, o_in_ready, o_out_valid;
  logic [1:0]       o_mac_mode, o_out_mode;
  logic [ACC_W-1:0] o_mac_psum, i_mac_result, o_out_data;
  logic [DAT_W-1:0] o_mac_a_data, o_mac_b_data;
  logic [SF_W-1:0]  o_mac_a_sf, o_mac_b_sf;
  logic             force_sat;
`ifdef MAC_SEQ_SAT_FLAG_EN
  logic             o_out_sat;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mac_seq #(.CNT_W(CNT_W), .ACC_W(ACC_W), .DAT_W(DAT_W), .SF_W(SF_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_mode(i_mode), .i_len(i_len),
    .o_busy(o_busy), .o_err(o_err), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_a_data(i_a_data), .i_b_data(i_b_data), .i_a_sf(i_a_sf), .i_b_sf(i_b_sf),
    .o_mac_mode(o_mac_mode), .o_mac_psum(o_mac_psum), .o_mac_a_data(o_mac_a_data),
    .o_mac_b_data(o_mac_b_data), .o_mac_a_sf(o_mac_a_sf), .o_mac_b_sf(o_mac_b_sf),
    .i_mac_result(i_mac_result), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
`ifdef MAC_SEQ_SAT_FLAG_EN
    .o_out_sat(o_out_sat),
`endif
    .o_out_data(o_out_data), .o_out_mode(o_out_mode)
  );

  assign i_mac_result = force_sat ? SAT_MAX : o_mac_psum + ACC_W'(1);

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts a job and steps through ACC until o_out_valid; pat[k] is in_valid for ACC cycle k+1
  task automatic run_job(input logic [1:0] mode, input logic [CNT_W-1:0] len,
                         input logic [15:0] pat, input int mid_start, input int sat_beat,
                         output int cyc, output int hs, output logic [ACC_W-1:0] data,
                         output logic [1:0] om, output logic sat);
    int p;
    @(negedge i_clk);
    i_start = 1'b1; i_mode = mode; i_len = len; i_in_valid = 1'b0;
    cyc = 0; hs = 0; p = 0; sat = 1'b0; data = '0; om = 2'd0;
    while (1) begin
      @(negedge i_clk);
      cyc++;
      if (mid_start != 0 && p == mid_start) check("mid_start_err", o_err, 1'b0);
      if (o_out_valid) begin
        data = o_out_data;
        om   = o_out_mode;
`ifdef MAC_SEQ_SAT_FLAG_EN
        sat  = o_out_sat;
`endif
        break;
      end
      if (cyc > 100) begin
        check("job_timeout", 1'b0, 1'b1);
        break;
      end
      p++;
      i_in_valid = (p <= 16) ? pat[p-1] : 1'b1;
      i_start = (p == mid_start);
      i_mode  = (p == mid_start) ? `INT4 : mode;
      i_len   = (p == mid_start) ? CNT_W'(1) : len;
      i_b_data = DAT_W'(32'hB000 + p);
      #1;
      if (o_in_ready && i_in_valid) begin
        hs++;
        force_sat = (hs == sat_beat);
      end else begin
        force_sat = 1'b0;
      end
      if (o_in_ready && !i_in_valid) begin
        check("b_data_gated", o_mac_b_data, '0);
        check("b_sf_gated", o_mac_b_sf, '0);
      end
    end
    i_start = 1'b0; i_in_valid = 1'b0; force_sat = 1'b0; i_mode = mode; i_len = len;
  endtask

  int cyc, hs;
  logic [ACC_W-1:0] data;
  logic [1:0] om;
  logic sat;

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_mode = 2'd0; i_len = '0; i_in_valid = 1'b0;
    i_out_ready = 1'b0; i_a_data = 32'hA5A5_0001; i_b_data = 32'h0000_B000;
    i_a_sf = 8'h3C; i_b_sf = 8'h5A; force_sat = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_busy", o_busy, 1'b0);
    check("rst_err", o_err, 1'b0);
    check("rst_in_ready", o_in_ready, 1'b0);
    check("rst_out_valid", o_out_valid, 1'b0);
    check("rst_out_data", o_out_data, '0);
    check("rst_mac_psum", o_mac_psum, '0);
    check("rst_mac_a", o_mac_a_data, '0);
    i_rst_n = 1'b1;

    // INT8, len 4, valid always high
    i_out_ready = 1'b1;
    run_job(`INT8, 8'd4, 16'hFFFF, 0, 0, cyc, hs, data, om, sat);
    check("t1_latency", cyc, 5);
    check("t1_hs", hs, 4);
    check("t1_data", data, 4);
    check("t1_mode", om, `INT8);
    @(negedge i_clk);
    check("t1_busy_drop", o_busy, 1'b0);

    // INT4_VSQ, len 3, valid 1,0,1,0,1
    run_job(`INT4_VSQ, 8'd3, 16'b0000_0000_0001_0101, 0, 0, cyc, hs, data, om, sat);
    check("t2_latency", cyc, 6);
    check("t2_hs", hs, 3);
    check("t2_data", data, 3);
    check("t2_mode", om, `INT4_VSQ);
    @(negedge i_clk);

    // INT4, len 0, output stalled for 5 cycles
    i_out_ready = 1'b0;
    run_job(`INT4, 8'd0, 16'hFFFF, 0, 0, cyc, hs, data, om, sat);
    check("t3_latency", cyc, 1);
    check("t3_hs", hs, 0);
    check("t3_data", data, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check("t3_hold_valid", o_out_valid, 1'b1);
      check("t3_hold_data", o_out_data, 0);
      check("t3_hold_mode", o_out_mode, `INT4);
    end
    i_out_ready = 1'b1;
    @(negedge i_clk);
    check("t3_busy_drop", o_busy, 1'b0);

    // Illegal mode rejected with a single error pulse
    i_start = 1'b1; i_mode = 2'd3; i_len = 8'd2;
    @(negedge i_clk);
    i_start = 1'b0;
    check("t4_err_pulse", o_err, 1'b1);
    check("t4_busy", o_busy, 1'b0);
    check("t4_mode_unlatched", o_mac_mode, `INT4);
    @(negedge i_clk);
    check("t4_err_clear", o_err, 1'b0);
    check("t4_busy2", o_busy, 1'b0);

    // Start pulsed mid-job is ignored
    run_job(`INT8, 8'd5, 16'hFFFF, 2, 0, cyc, hs, data, om, sat);
    check("t5_data", data, 5);
    check("t5_mode", om, `INT8);
    @(negedge i_clk);

    // Reset after 2 of 6 beats, then a clean len 2 job
    i_start = 1'b1; i_mode = `INT8; i_len = 8'd6; i_in_valid = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (2) @(negedge i_clk);
    check("t6_psum_mid", o_mac_psum, 2);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    check("t6_busy", o_busy, 1'b0);
    check("t6_in_ready", o_in_ready, 1'b0);
    check("t6_out_valid", o_out_valid, 1'b0);
    check("t6_psum", o_mac_psum, '0);
    check("t6_mac_a", o_mac_a_data, '0);
    check("t6_mac_b", o_mac_b_data, '0);
    check("t6_mac_mode", o_mac_mode, 2'd0);
    i_rst_n = 1'b1; i_in_valid = 1'b0;
    run_job(`INT8, 8'd2, 16'hFFFF, 0, 0, cyc, hs, data, om, sat);
    check("t6_new_data", data, 2);
    check("t6_new_hs", hs, 2);
    @(negedge i_clk);

`ifdef MAC_SEQ_SAT_FLAG_EN
    run_job(`INT4_VSQ, 8'd3, 16'hFFFF, 0, 2, cyc, hs, data, om, sat);
    check("t7_sat_set", sat, 1'b1);
    @(negedge i_clk);
    run_job(`INT8, 8'd2, 16'hFFFF, 0, 0, cyc, hs, data, om, sat);
    check("t7_sat_clear", sat, 1'b0);
    check("t7_data", data, 2);
    @(negedge i_clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Sequencer for one `mac` lane. Accepts a job (mode, vector count) and streams operand beats in over valid/ready.
- Drives the mac ports combinationally and holds the running partial sum in a register that feeds back as psum.
- Emits the final accumulated result over valid/ready.
- Sits between the operand buffers and the output writeback of each PE row.

Parameters:
- CNT_W, 8, width of the job length and beat counter (maximum job = 2^CNT_W-1 beats).
- ACC_W, `ACC_W, accumulator/result width.
- DAT_W, `DAT_W, packed operand vector width.
- SF_W, `SF_W, scale-factor width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_start  in  1  job start pulse, sampled in IDLE only.
- i_mode  in  2  job mode: `INT4, `INT8 or `INT4_VSQ.
- i_len  in  CNT_W  number of operand beats in the job.
- o_busy  out  1  high in any state other than IDLE.
- o_err  out  1  one-cycle pulse when a start is rejected.
- i_in_valid  in  1  operand beat valid.
- o_in_ready  out  1  operand beat ready.
- i_a_data  in  DAT_W  operand A vector.
- i_b_data  in  DAT_W  operand B vector.
- i_a_sf  in  SF_W  A scale factor.
- i_b_sf  in  SF_W  B scale factor.
- o_mac_mode  out  2  mode to mac.
- o_mac_psum  out  ACC_W  psum to mac.
- o_mac_a_data  out  DAT_W  A data to mac.
- o_mac_b_data  out  DAT_W  B data to mac.
- o_mac_a_sf  out  SF_W  A scale factor to mac.
- o_mac_b_sf  out  SF_W  B scale factor to mac.
- i_mac_result  in  ACC_W  mac result.
- o_out_valid  out  1  result valid.
- i_out_ready  in  1  result ready.
- o_out_data  out  ACC_W  accumulated result.
- o_out_mode  out  2  mode of the job that produced o_out_data.

Behaviour:
- One clock, i_clk. Reset is synchronous, active-low on i_rst_n. All state updates on the rising edge of i_clk.
- Reset values: state=IDLE; acc, cnt, mode_q, len_q = 0. Every output is 0, including o_busy, o_err, o_in_ready and o_out_valid.
- Reset asserted mid-job aborts the job: no output is produced and any partial beat is dropped.
- IDLE:
  - i_start with a legal i_mode: latch mode_q and len_q, clear acc and cnt.
  - If i_len==0, go to OUT; the job result is 0.
  - Otherwise go to ACC.
  - i_start with an illegal mode (the fourth encoding): stay in IDLE, pulse o_err for one cycle, latch nothing.
- i_start outside IDLE is ignored; no o_err.
- ACC:
  - o_in_ready=1.
  - o_mac_mode=mode_q and o_mac_psum=acc at all times.
  - o_mac_a_data and o_mac_a_sf pass through from the inputs.
  - o_mac_b_data and o_mac_b_sf equal the inputs only when i_in_valid=1, and are forced to 0 otherwise (operand gating).
  - On a handshake (i_in_valid & o_in_ready): acc <= i_mac_result and cnt <= cnt+1.
  - On the handshake where cnt==len_q-1, go to OUT.
  - No handshake: acc and cnt hold.
- OUT:
  - o_out_valid=1, o_out_data=acc, o_out_mode=mode_q, o_in_ready=0.
  - On i_out_ready go to IDLE and clear acc.
  - o_out_data and o_out_mode stay stable while valid and not ready.
- In IDLE and OUT, all o_mac_* data and scale-factor outputs are 0, and o_mac_mode=mode_q.
- Timing: the first ACC cycle is the cycle after i_start. o_out_valid asserts the cycle after the last input handshake. With no stalls, latency from i_start to o_out_valid is i_len+1 cycles.
- The earliest next start is the cycle after the output handshake; there is no start-in-OUT overlap.
- Arithmetic: the block does no arithmetic on data. Saturation is the mac's responsibility; acc is a plain ACC_W register. cnt is CNT_W wide and never wraps, because len_q ≤ 2^CNT_W-1.

Optional Feature:
- Macro: MAC_SEQ_SAT_FLAG_EN.
- Defined: an extra output port o_out_sat (1 bit) is present.
  - A sticky flag is set on any ACC handshake where i_mac_result equals +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)-1), i.e. the mac saturation limits.
  - o_out_sat carries the flag alongside o_out_valid.
  - The flag is cleared on job start and on reset.
- Undefined: o_out_sat and the flag logic are absent; all other behaviour is identical.

Test Plan:
- Bench mac model returns psum+1. Start with `INT8, len=4, i_in_valid held high, i_out_ready high → o_out_valid at cycle 5 after start, o_out_data=4, o_out_mode=`INT8, o_busy drops the cycle after the output handshake.
- `INT4_VSQ, len=3, i_in_valid toggled 1,0,1,0,1 → exactly 3 handshakes, o_out_data=3; o_mac_b_data and o_mac_b_sf are 0 in the cycles where valid is low.
- len=0 with `INT4 → o_out_valid the cycle after start, o_out_data=0, no input handshake occurs. Hold i_out_ready low for 5 cycles → data stable, state held.
- Start with the illegal mode → o_err single pulse, o_busy stays 0. i_start pulsed during ACC of a len=5 job → ignored, result=5.
- Assert i_rst_n=0 after 2 of 6 beats → all outputs 0 next edge. Then a new len=2 job → o_out_data=2, with no leftover acc.
- MAC_SEQ_SAT_FLAG_EN defined; model returns +(2^(ACC_W-1)-1) on beat 2 of 3 → o_out_sat=1. Next job with no saturation → o_out_sat=0.
